flash_read_responder: RTL
=========================

Name: flash_read_responder

Overview:
- Responder end of the flash read handshake used by the audio address/playback FSM.
- Accepts a start/read request with a 23-bit word address, issues one Avalon-MM read to the flash controller, and captures the 32-bit word.
- Returns the word on song_data with a one-cycle end_flash pulse.
- Sits between the playback FSM and the flash IP, on the 50 MHz domain.

Parameters:
- ADDR_W, 23, word address width, for both the request side and the flash side.
- DATA_W, 32, flash word width.
- TIMEOUT_CYCLES, 255, maximum cycles spent in ISSUE+WAIT_DATA before the transaction is aborted; must be ≥ 2.

Ports:
- clk  in  1  50 MHz system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe; held high by the initiator until end_flash.
- read  in  1  read qualifier; a request is accepted only when start && read.
- address  in  ADDR_W  word address of the request.
- byteenable  in  4  byte lanes for the request.
- end_flash  out  1  one-cycle pulse; song_data is valid in the same cycle.
- song_data  out  DATA_W  captured flash word.
- flash_err  out  1  sticky timeout flag.
- flash_mem_read  out  1  Avalon read.
- flash_mem_address  out  ADDR_W  Avalon address.
- flash_mem_byteenable  out  4  Avalon byteenable.
- flash_mem_burstcount  out  6  constant 1.
- flash_mem_waitrequest  in  1  Avalon waitrequest.
- flash_mem_readdata  in  DATA_W  Avalon read data.
- flash_mem_readdatavalid  in  1  Avalon read-data valid.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - end_flash=0, song_data=0, flash_err=0, flash_mem_read=0.
  - flash_mem_address=0, flash_mem_byteenable=0, timeout counter=0.
- IDLE: on start && read, latch address → flash_mem_address and byteenable → flash_mem_byteenable, set flash_mem_read=1, clear counter, go to ISSUE. start without read is ignored.
- ISSUE:
  - flash_mem_read stays 1 and address/byteenable stay stable while waitrequest=1.
  - At the first edge with waitrequest=0, drop flash_mem_read and go to WAIT_DATA.
  - If readdatavalid=1 in that same cycle, capture readdata and go directly to DONE.
- WAIT_DATA: on readdatavalid=1, song_data ← readdata, go to DONE. readdatavalid seen in IDLE or DONE is ignored.
- DONE: end_flash=1 for exactly this cycle, then go to IDLE.
- Latency with zero-wait flash and readdatavalid one cycle after accept: start high at edge N → end_flash high in the cycle after edge N+2.
- Timeout:
  - The counter increments every cycle in ISSUE or WAIT_DATA.
  - When it reaches TIMEOUT_CYCLES: force flash_mem_read=0, song_data ← 0, set flash_err=1, go to DONE so end_flash still pulses. The initiator never hangs.
  - flash_err clears only on reset.
- song_data holds its value between transactions and changes only on capture or timeout.
- The request inputs are sampled only in IDLE. Address changes mid-transaction are ignored.
- If start is still high in the cycle after DONE, it is treated as a new request.
- Reset mid-transaction returns to IDLE immediately with all outputs at reset values. A late readdatavalid from the aborted read, arriving in IDLE, is dropped.
- flash_mem_burstcount is tied to 1.

Optional Feature:
- Macro FLASH_RESP_LAST_WORD_CACHE_EN.
- When defined:
  - Keep a last-word register plus a valid bit; valid is cleared by reset and by a timeout.
  - In IDLE, a request whose address equals the last completed address, with valid=1, goes straight to DONE with no Avalon read issued (end_flash one cycle after acceptance). song_data keeps the cached word.
  - Each successful capture updates the tag and sets valid.
- When undefined: every request issues an Avalon read. No cache registers exist.

Test Plan:
- Reset, then address=23'h000010, zero waitrequest, readdatavalid one cycle later with readdata=32'hA1B2C3D4 → flash_mem_read high exactly 1 cycle with address 0x10; end_flash pulses once; song_data=32'hA1B2C3D4; flash_err=0.
- waitrequest held high 5 cycles, address=23'h7FFFF → flash_mem_read and address stable for all 6 cycles, a single read accepted, end_flash pulses once after readdatavalid.
- Flash never asserts readdatavalid, TIMEOUT_CYCLES=255 → flash_mem_read=0 after acceptance, end_flash pulses 255 cycles after the request, song_data=0, flash_err=1 and stays 1 until reset.
- reset_n pulsed low while in WAIT_DATA, then readdatavalid=1 with data 32'hDEADBEEF → all outputs go to 0 asynchronously, no end_flash, song_data stays 0.
- start=1, read=0 for 10 cycles → no flash_mem_read, no end_flash; then read=1 → a normal transaction completes.
- With FLASH_RESP_LAST_WORD_CACHE_EN defined, two back-to-back requests to 23'h000020 → the first issues an Avalon read; the second produces end_flash one cycle after acceptance with flash_mem_read never asserted and song_data unchanged.

Source files
------------

// File: rtl/flash_read_responder_if.sv
// flash_read_responder_if
//   Avalon-MM read channel between the flash read responder and the flash
//   controller IP.
//   master modport : responder side (drives read/address/byteenable/burstcount)
//   slave  modport : flash controller side (drives waitrequest/readdata/readdatavalid)
interface flash_read_responder_if #(
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned DATA_W = 32
);
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic [5:0]        burstcount;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output read, address, byteenable, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  read, address, byteenable, burstcount,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/flash_read_responder.sv
// flash_read_responder
//   Responder end of the playback FSM's flash read handshake. Accepts a
//   start&&read request, issues a single Avalon-MM read, captures the word
//   and returns it on song_data with a one-cycle end_flash pulse. A bounded
//   timeout guarantees end_flash always pulses (flash_err flags the abort).
//
//   Ports:
//     clk, reset_n       50 MHz clock, asynchronous active-low reset
//     start, read        request strobe / qualifier (accepted on start&&read)
//     address            request word address (ADDR_W)
//     byteenable         request byte lanes
//     end_flash          one-cycle completion pulse, song_data valid with it
//     song_data          captured flash word (0 after a timeout)
//     flash_err          sticky timeout flag, cleared only by reset
//     flash_mem          Avalon-MM read master (flash_read_responder_if.master)
//
//   Optional build macro: FLASH_RESP_LAST_WORD_CACHE_EN
//     Adds a single-entry last-word cache; a repeated request to the last
//     successfully read address completes without an Avalon read.
module flash_read_responder #(
  parameter int unsigned ADDR_W         = 23,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [3:0]        byteenable,
  output logic              end_flash,
  output logic [DATA_W-1:0] song_data,
  output logic              flash_err,
  flash_read_responder_if.master flash_mem
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DATA,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              end_flash_q, end_flash_d;
  logic [DATA_W-1:0] song_data_q, song_data_d;
  logic              flash_err_q, flash_err_d;
  logic              mem_read_q, mem_read_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic              capture;
  logic [CNT_W-1:0]  cnt_inc;

`ifdef FLASH_RESP_LAST_WORD_CACHE_EN
  logic              cache_valid_q, cache_valid_d;
  logic [ADDR_W-1:0] cache_tag_q, cache_tag_d;
  logic [DATA_W-1:0] cache_word_q, cache_word_d;
`endif

  always_comb begin
    state_d     = state_q;
    end_flash_d = 1'b0;
    song_data_d = song_data_q;
    flash_err_d = flash_err_q;
    mem_read_d  = mem_read_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    cnt_d       = cnt_q;
    accept      = start && read;
    capture     = 1'b0;
    cnt_inc     = cnt_q + 1'b1;
`ifdef FLASH_RESP_LAST_WORD_CACHE_EN
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_word_d  = cache_word_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mem_addr_d = address;
          mem_be_d   = byteenable;
          cnt_d      = '0;
`ifdef FLASH_RESP_LAST_WORD_CACHE_EN
          if (cache_valid_q && (address == cache_tag_q)) begin
            song_data_d = cache_word_q;
            end_flash_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            mem_read_d = 1'b1;
            state_d    = S_ISSUE;
          end
`else
          mem_read_d = 1'b1;
          state_d    = S_ISSUE;
`endif
        end
      end

      S_ISSUE, S_WAIT_DATA: begin
        cnt_d = cnt_inc;
        if (state_q == S_ISSUE) begin
          // readdatavalid only counts once the read has been accepted.
          if (!flash_mem.waitrequest) begin
            mem_read_d = 1'b0;
            state_d    = S_WAIT_DATA;
            capture    = flash_mem.readdatavalid;
          end
        end else begin
          capture = flash_mem.readdatavalid;
        end

        // A capture on the timeout cycle wins: the data did arrive in time.
        if (capture) begin
          song_data_d = flash_mem.readdata;
          end_flash_d = 1'b1;
          state_d     = S_DONE;
`ifdef FLASH_RESP_LAST_WORD_CACHE_EN
          cache_valid_d = 1'b1;
          cache_tag_d   = mem_addr_q;
          cache_word_d  = flash_mem.readdata;
`endif
        end else if (cnt_inc == CNT_LAST) begin
          mem_read_d  = 1'b0;
          song_data_d = '0;
          flash_err_d = 1'b1;
          end_flash_d = 1'b1;
          state_d     = S_DONE;
`ifdef FLASH_RESP_LAST_WORD_CACHE_EN
          cache_valid_d = 1'b0;
`endif
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d    = S_IDLE;
        mem_read_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      end_flash_q <= 1'b0;
      song_data_q <= '0;
      flash_err_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      cnt_q       <= '0;
`ifdef FLASH_RESP_LAST_WORD_CACHE_EN
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_word_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      end_flash_q <= end_flash_d;
      song_data_q <= song_data_d;
      flash_err_q <= flash_err_d;
      mem_read_q  <= mem_read_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      cnt_q       <= cnt_d;
`ifdef FLASH_RESP_LAST_WORD_CACHE_EN
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_word_q  <= cache_word_d;
`endif
    end
  end

  assign end_flash             = end_flash_q;
  assign song_data             = song_data_q;
  assign flash_err             = flash_err_q;
  assign flash_mem.read        = mem_read_q;
  assign flash_mem.address     = mem_addr_q;
  assign flash_mem.byteenable  = mem_be_q;
  assign flash_mem.burstcount  = 6'd1;

endmodule
